// File: rtl/serial_add_nbit_pkg.sv
// add_defs: shared state encoding and width constants for the serial adder.
package add_defs;
  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;
  localparam int ADD_W = 4;
  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction
  localparam int ADD_CW = cnt_w(ADD_W);
endpackage

// File: rtl/serial_add_nbit_fa1bit.sv
// fa1bit: combinational 1-bit full adder cell.
module fa1bit (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_co
);
  assign o_s  = i_a ^ i_b ^ i_c;
  assign o_co = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
endmodule

// File: rtl/serial_add_nbit.sv
// serial_add_nbit: bit-serial N-bit adder, one bit per clock LSB first.
// Define SERIAL_ADD_OVF_EN to add a registered signed-overflow output ovf.
module serial_add_nbit
  import add_defs::*;
#(
  parameter int N  = ADD_W,
  parameter int CW = ADD_CW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         ci,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] s,
  output logic         co
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic         ovf
`endif
);
  state_t        r_state;
  logic [N-1:0]  r_sh_a, r_sh_b, r_sh_s, r_s;
  logic [CW-1:0] r_cnt;
  logic          r_cy, r_busy, r_done, r_co;
  logic          w_sbit, w_cout;
  fa1bit u_fa (
    .i_a (r_sh_a[0]),
    .i_b (r_sh_b[0]),
    .i_c (r_cy),
    .o_s (w_sbit),
    .o_co(w_cout)
  );
`ifdef SERIAL_ADD_OVF_EN
  logic r_ovf;
  assign ovf = r_ovf;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_sh_a  <= '0;
      r_sh_b  <= '0;
      r_sh_s  <= '0;
      r_s     <= '0;
      r_cnt   <= '0;
      r_cy    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_co    <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      if (r_state == ST_IDLE) begin
        if (start) begin
          r_sh_a  <= A;
          r_sh_b  <= B;
          r_cy    <= ci;
          r_cnt   <= '0;
          r_state <= ST_RUN;
          r_busy  <= 1'b1;
        end
      end else begin
        r_sh_a <= r_sh_a >> 1;
        r_sh_b <= r_sh_b >> 1;
        r_sh_s <= {w_sbit, r_sh_s[N-1:1]};
        r_cy   <= w_cout;
        r_cnt  <= r_cnt + 1'b1;
        if (r_cnt == CW'(N - 1)) begin
          r_s     <= {w_sbit, r_sh_s[N-1:1]};
          r_co    <= w_cout;
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
          // r_cy here is the carry into the MSB position
          r_ovf   <= r_cy ^ w_cout;
`endif
        end
      end
    end
  end
  assign busy = r_busy;
  assign done = r_done;
  assign s    = r_s;
  assign co   = r_co;
endmodule

// File: tb/tb_serial_add_nbit.sv
// tb_serial_add_nbit: scoreboard bench for serial_add_nbit at N=4.
module tb_serial_add_nbit;
  localparam int N = 4;
  typedef struct packed {
    logic [N:0] sum;
    logic       ovf;
  } exp_t;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] A = '0, B = '0;
  logic         ci = 1'b0;
  logic         busy, done, co;
  logic [N-1:0] s;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif
  int tests = 0, fails = 0, n_start = 0, n_done = 0;
  exp_t q[$];
  serial_add_nbit #(.N(N), .CW(3)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .A    (A),
    .B    (B),
    .ci   (ci),
    .busy (busy),
    .done (done),
    .s    (s),
    .co   (co)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf  (ovf)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b, input logic c);
    exp_t e;
    logic [N-1:0] lo;
    e.sum = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c};
    lo = {1'b0, a[N-2:0]} + {1'b0, b[N-2:0]} + {{(N-1){1'b0}}, c};
    e.ovf = lo[N-1] ^ e.sum[N];
    return e;
  endfunction
  always @(posedge clk) begin
    #1;
    if (!rst && done) begin
      n_done++;
      if (q.size() == 0) chk("spurious_done", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("sum", {27'd0, co, s}, {27'd0, e.sum});
`ifdef SERIAL_ADD_OVF_EN
        chk("ovf", {31'd0, ovf}, {31'd0, e.ovf});
`endif
      end
    end
  end
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic c,
                        input bit poke, input bit lat);
    @(negedge clk);
    A = a; B = b; ci = c; start = 1'b1;
    q.push_back(model(a, b, c));
    n_start++;
    for (int i = 1; i <= N; i++) begin
      @(negedge clk);
      start = poke && i <= 2;
      if (poke) begin A = $urandom; B = $urandom; ci = $urandom; end
      @(posedge clk);
      #2;
      if (lat) begin
        chk("done_lat", {31'd0, done}, {31'd0, i == N});
        chk("busy_run", {31'd0, busy}, {31'd0, i != N});
      end
    end
    start = 1'b0;
  endtask
  initial begin
    #12;
    chk("rst_s", {27'd0, co, s}, 0);
    chk("rst_busy", {30'd0, busy, done}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    A = 5; B = 3; ci = 0; start = 1'b1;
    q.push_back(model(5, 3, 0));
    n_start++;
    @(posedge clk);
    #2;
    chk("busy_edge0", {31'd0, busy}, 1);
    start = 1'b0;
    for (int i = 1; i <= N; i++) begin
      @(posedge clk);
      #2;
      chk("done_first", {31'd0, done}, {31'd0, i == N});
    end
    repeat (3) @(posedge clk);
    #2;
    chk("s_hold", {27'd0, co, s}, 8);
    chk("done_low", {31'd0, done}, 0);
    run_op(15, 1, 0, 0, 1);
    run_op(7, 8, 1, 0, 1);
    run_op(2, 3, 0, 1, 1);
    run_op(6, 1, 1, 0, 1);
    run_op(5, 6, 0, 0, 0);
    @(negedge clk);
    A = 12; B = 2; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("mid_rst_s", {27'd0, co, s}, 0);
    chk("mid_rst_busy", {31'd0, busy}, 0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    chk("no_done_after_rst", {31'd0, done}, 0);
    chk("idle_after_rst", {31'd0, busy}, 0);
    run_op(9, 4, 0, 0, 1);
    run_op(7, 1, 0, 0, 1);
    run_op(8, 8, 0, 0, 1);
    run_op(3, 2, 0, 0, 1);
    n_start = 0;
    n_done = 0;
    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = 9'(i * 173 + 61);
      run_op(v[3:0], v[7:4], v[8], 0, 0);
    end
    repeat (3) @(posedge clk);
    #2;
    chk("sweep_done_count", n_done, n_start);
    chk("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #400000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/serial_add_nbit.md
Name: serial_add_nbit

Overview:
- Bit-serial N-bit adder; the addition-side counterpart of the team's ripple-borrow subtractor datapath.
- Latches A, B and ci on a start handshake, then processes one bit per clock, LSB first, through a single 1-bit full-adder cell.
- Presents the registered sum and carry-out with a one-cycle done pulse.
- Used where area matters more than latency, e.g. the ALU lab datapath add path.

Parameters:
- N, 4, operand/result width in bits (N >= 2).
- CW, 3, bit-counter width; must satisfy 2**CW >= N.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when state is IDLE.
- A  input  N  augend, captured on accepted start.
- B  input  N  addend, captured on accepted start.
- ci  input  1  carry-in, captured on accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when s/co become valid.
- s  output  N  sum, registered, held until the next completion.
- co  output  1  carry-out, registered, held until the next completion.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high. On rst: state=IDLE, busy=0, done=0, s=0, co=0, shift registers/counter/carry FF = 0.
- States: IDLE, RUN. Encoding comes from the shared package.
- IDLE, start=1 at edge t:
  - load shA<=A, shB<=B, cy<=ci, cnt<=0;
  - state<=RUN; busy=1 from edge t.
- IDLE, start=0: stay; done=0.
- RUN, each edge:
  - full-adder cell gets (shA[0], shB[0], cy) and produces (sbit, cout);
  - sum register shifts right with sbit entering MSB; shA/shB shift right; cy<=cout; cnt<=cnt+1.
- RUN, edge where cnt==N-1 (the edge processing the last bit):
  - s<=final shifted sum, co<=cout, done<=1, state<=IDLE, busy<=0.
  - This completion edge is edge t+N, so latency = N clocks from the accepted start edge.
- done is high for exactly one cycle, deasserted on the next edge.
- start while busy=1: ignored. Operands are not re-captured and there is no error flag.
- start during the done cycle (state already IDLE): accepted. Back-to-back operations give one result every N+1 edges minimum.
- s/co hold their last values while a new operation runs; they change only at completion.
- Arithmetic: unsigned, {co,s} = A + B + ci mod 2**(N+1). No saturation. Wrap-around: A=2**N-1, B=0, ci=1 gives s=0, co=1.
- Reset mid-RUN: operation aborted immediately (async). Outputs return to reset values and no done pulse is produced. A new start is required after rst deasserts.
- rst deassertion is assumed synchronous to clk externally. The block does not resynchronize rst.

Optional Feature:
- Macro SERIAL_ADD_OVF_EN.
- Defined: extra output port ovf (1 bit), registered at completion together with s/co. ovf = carry into MSB XOR carry out of MSB (two's-complement signed overflow). Reset value 0; held until the next completion.
- Undefined: no ovf port, no extra flop; behaviour is otherwise identical.

Decomposition:
- Shared package/include `add_defs`:
  - state encodings ST_IDLE=1'b0, ST_RUN=1'b1;
  - default width constant ADD_W=4;
  - the counter-width helper constant.
- Sub-module: fa1bit (combinational 1-bit full adder: s=a^b^c, co=a&b|a&c|b&c), instantiated once.
- Everything else (FSM, shift registers, counter, output registers) stays in serial_add_nbit.

Test Plan:
- Reset, then A=5, B=3, ci=0, start at edge 0 -> busy=1 on edges 0-3; done=1 only after edge 4; s=8, co=0; s/co unchanged afterwards.
- A=15, B=1, ci=0 -> s=0, co=1. Then A=7, B=8, ci=1 -> s=0, co=1 (wrap-around, full-range carry).
- start pulsed again at edges 1 and 2 of a run with different A/B -> ignored; result matches the first operands. Then start during the done cycle -> accepted; second done exactly 4 cycles later.
- rst asserted mid-RUN at edge 2 -> s=0, co=0, busy=0 immediately; no done pulse. A following start with A=9, B=4 -> s=13, co=0.
- With SERIAL_ADD_OVF_EN: 7+1 -> s=8, ovf=1. Then 8+8 -> s=0, co=1, ovf=1. Then 3+2 -> ovf=0. Without the macro: same sums, and the port is absent.
- Random sweep of all 512 (A, B, ci) combinations at N=4 against the golden model {co,s}=A+B+ci; exactly one done per accepted start.
